// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic single-transfer command initiator with timeout
module wb_cmd_master #(
  parameter int TIMEOUT   = 1023,
  parameter int TIMEOUT_W = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_status,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [15:0] txn_count,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [TIMEOUT_W-1:0] TMAX = TIMEOUT_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [3:0]           sel_q, sel_d;
  logic [31:0]          adr_q, adr_d, dat_o_q, dat_o_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_dat_q, rsp_dat_d;
  logic [1:0]           rsp_status_q, rsp_status_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [15:0]          txn_q, txn_d, err_q, err_d;
  logic                 term;

  // State and every output register; reset drops the bus cycle at once
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      adr_q        <= '0;
      dat_o_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= '0;
      timer_q      <= '0;
      txn_q        <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      adr_q        <= adr_d;
      dat_o_q      <= dat_o_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      timer_q      <= timer_d;
      txn_q        <= txn_d;
      err_q        <= err_d;
    end
  end

  // Next state: accept in IDLE, terminate in BUS (err > ack > timeout), hand off in RESP
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    sel_d        = sel_q;
    adr_d        = adr_q;
    dat_o_d      = dat_o_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    timer_d      = timer_q;
    txn_d        = txn_q;
    err_d        = err_q;
    term         = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          we_d        = cmd_we;
          sel_d       = cmd_sel;
          adr_d       = cmd_adr;
          dat_o_d     = cmd_we ? cmd_dat : 32'h0;
          timer_d     = '0;
          state_d     = BUS;
        end
      end
      BUS: begin
        term = 1'b1;
        if (wb_err_i) begin
          rsp_status_d = 2'b01;
          rsp_dat_d    = 32'h0;
        end else if (wb_ack_i) begin
          rsp_status_d = 2'b00;
          rsp_dat_d    = we_q ? 32'h0 : wb_dat_i;
        end else if (timer_q == TMAX) begin
          rsp_status_d = 2'b10;
          rsp_dat_d    = 32'h0;
        end else begin
          term    = 1'b0;
          timer_d = timer_q + 1'b1;
        end
        if (term) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = '0;
          adr_d       = '0;
          dat_o_d     = '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          txn_d       = txn_q + 16'd1;
          if (rsp_status_q != 2'b00 && err_q != 16'hFFFF) err_d = err_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready  = cmd_ready_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = we_q;
  assign wb_sel_o   = sel_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_o_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_dat    = rsp_dat_q;
  assign rsp_status = rsp_status_q;
  assign txn_count  = txn_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - directed table-driven bench for wb_cmd_master
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic [15:0] txn_count, err_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_txn = '0, exp_err = '0;

  always #5 clk = ~clk;

  wb_cmd_master #(.TIMEOUT(8), .TIMEOUT_W(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_sel(cmd_sel),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .txn_count(txn_count), .err_count(err_count)
  );

  // mode bit0 = slave acks, bit1 = slave errs, 0 = silent slave
  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdat;
    logic [1:0]  mode;
    int          dly;
    int          stall;
    logic        trail;
    logic [1:0]  exp_st;
    logic [31:0] exp_rd;
    int          exp_stb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    logic [31:0] held_dat;
    logic [1:0]  held_st;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_sel = v.sel; cmd_adr = v.adr; cmd_dat = v.dat;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = ~v.we; cmd_adr = 32'hFFFF_FFFF; cmd_dat = 32'h5A5A_5A5A;
    chk("cyc_up", {31'b0, wb_cyc_o}, 32'd1);
    chk("we_o", {31'b0, wb_we_o}, {31'b0, v.we});
    chk("sel_o", {28'b0, wb_sel_o}, {28'b0, v.sel});
    chk("adr_o", wb_adr_o, v.adr);
    chk("dat_o", wb_dat_o, v.we ? v.dat : 32'h0);
    chk("ready_busy", {31'b0, cmd_ready}, 32'd0);
    n = 0;
    while (wb_stb_o && n < 40) begin
      n++;
      if (v.mode != 2'b00 && n == v.dly + 1) begin
        wb_ack_i = v.mode[0]; wb_err_i = v.mode[1]; wb_dat_i = v.rdat;
      end else begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
      end
      @(negedge clk);
      if (wb_stb_o) chk("bus_stable", wb_adr_o, v.adr);
    end
    chk("stb_cycles", n, v.exp_stb);
    chk("rsp_valid_up", {31'b0, rsp_valid}, 32'd1);
    chk("rsp_status", {30'b0, rsp_status}, {30'b0, v.exp_st});
    chk("rsp_dat", rsp_dat, v.exp_rd);
    chk("bus_cleared", {wb_cyc_o, wb_we_o, wb_sel_o, 26'b0}, 32'd0);
    chk("adr_cleared", wb_adr_o | wb_dat_o, 32'd0);
    held_dat = rsp_dat; held_st = rsp_status;
    if (v.trail) begin
      @(negedge clk);
      chk("trail_rsp_hold", {31'b0, rsp_valid}, 32'd1);
      chk("trail_no_cyc", {31'b0, wb_cyc_o}, 32'd0);
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'hBAD0_BAD0;
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_dat", rsp_dat, held_dat);
      chk("stall_txn", {16'b0, txn_count}, {16'b0, exp_txn});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_txn = exp_txn + 16'd1;
    if (v.exp_st != 2'b00 && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    chk("rsp_valid_down", {31'b0, rsp_valid}, 32'd0);
    chk("txn_count", {16'b0, txn_count}, {16'b0, exp_txn});
    chk("err_count", {16'b0, err_count}, {16'b0, exp_err});
    chk("ready_after", {31'b0, cmd_ready}, 32'd1);
    chk("rsp_keep", {rsp_dat[31:2], rsp_status}, {held_dat[31:2], held_st});
    @(negedge clk);
    chk("no_extra_rsp", {31'b0, rsp_valid | wb_cyc_o}, 32'd0);
  endtask

  initial begin
    vec_t v;
    //          we    sel    adr           dat           rdat          mode  dly stall trail st     exp_rd        stb
    vecs[0] = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1111_1111, 2'd1, 1, 0, 1'b0, 2'b00, 32'h0,         2};
    vecs[1] = '{1'b0, 4'hF, 32'h0000_0000, 32'h7777_7777, 32'h1234_5678, 2'd1, 5, 3, 1'b0, 2'b00, 32'h1234_5678, 6};
    vecs[2] = '{1'b0, 4'hF, 32'h0000_0040, 32'h0,         32'h0,         2'd0, 0, 0, 1'b0, 2'b10, 32'h0,         8};
    vecs[3] = '{1'b0, 4'hF, 32'h0000_0044, 32'h0,         32'hAAAA_5555, 2'd3, 0, 0, 1'b1, 2'b01, 32'h0,         1};
    vecs[4] = '{1'b1, 4'h3, 32'h0000_0048, 32'h0102_0304, 32'h0,         2'd2, 2, 1, 1'b0, 2'b01, 32'h0,         3};
    vecs[5] = '{1'b0, 4'h4, 32'h1000_0004, 32'h0,         32'hCAFE_F00D, 2'd1, 0, 0, 1'b1, 2'b00, 32'hCAFE_F00D, 1};
    vecs[6] = '{1'b1, 4'hC, 32'h0000_0050, 32'h9999_0000, 32'h0,         2'd1, 7, 0, 1'b0, 2'b00, 32'h0,         8};

    repeat (2) @(negedge clk);
    chk("rst_outs", {cmd_ready, rsp_valid, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, rsp_status, 21'b0}, 32'd0);
    chk("rst_buses", wb_adr_o | wb_dat_o | rsp_dat, 32'd0);
    chk("rst_cnt", {txn_count, err_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, cmd_ready}, 32'd1);

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // asynchronous reset in the middle of a bus cycle
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h20;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_bus_cyc", {31'b0, wb_cyc_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_drop", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("async_cnt", {txn_count, err_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_txn = '0; exp_err = '0;
    repeat (12) @(negedge clk);
    chk("post_rst_quiet", {30'b0, rsp_valid, wb_cyc_o}, 32'd0);
    chk("post_rst_cnt", {txn_count, err_count}, 32'd0);
    run_txn(vecs[5]);

    // counter saturation and wrap from a preloaded near-full state
    @(negedge clk);
    force dut.txn_q = 16'hFFFE;
    force dut.err_q = 16'hFFFE;
    @(negedge clk);
    release dut.txn_q;
    release dut.err_q;
    @(negedge clk);
    exp_txn = 16'hFFFE; exp_err = 16'hFFFE;
    chk("preload", {txn_count, err_count}, 32'hFFFE_FFFE);
    run_txn(vecs[4]);
    chk("reach_full", {txn_count, err_count}, 32'hFFFF_FFFF);
    run_txn(vecs[4]);
    chk("sat_wrap", {txn_count, err_count}, 32'h0000_FFFF);
    v = vecs[0];
    run_txn(v);
    chk("ok_after_wrap", {txn_count, err_count}, 32'h0001_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
